tree_node_writer: RTL

// Write side of the per-level node BRAMs that the tree lookup stages (TreeLevelN) read

---
 rtl/tree_node_writer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tree_node_writer.sv
// ---------------------------------------------------------------------------
// tree_node_writer
// Purpose: loads tree nodes into the per-level node BRAMs at run time. This
//   block converts a 32-bit configuration word stream (valid/ready) into
//   40-bit node writes on a dedicated BRAM write port. The port is shared by
//   all levels and selected by a one-hot write enable.
// Transaction: one header word, then two payload words per node:
//   - the LO word carries node bits [31:0];
//   - the HI word carries node bits [39:32] in its bits [7:0].
//   Header fields:
//     [31:28] opcode (4'h1 = write nodes)
//     [27:24] level
//     [20:12] base address
//     [9:0]   node count
// Ports:
//   clk        clock
//   RSTn       asynchronous active-low reset
//   cfg_word   configuration word (header or payload)
//   cfg_valid  cfg_word valid
//   cfg_ready  block accepts cfg_word this cycle
//   wr_en      one-hot BRAM write enable, bit i -> level i
//   wr_addr    BRAM write address (held when wr_en = 0)
//   wr_data    node written (held when wr_en = 0)
//   busy       transaction in progress
//   done       1-cycle pulse, one cycle after the last write slot
//   err        sticky illegal-level flag, cleared by the next write header
// ---------------------------------------------------------------------------
module tree_node_writer #(
  parameter int NODE_WIDTH = 40,
  parameter int NODE_ADDR  = 9,
  parameter int LEVELS     = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [WORD_WIDTH-1:0] cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [LEVELS-1:0]     wr_en,
  output logic [NODE_ADDR-1:0]  wr_addr,
  output logic [NODE_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int         HI_WIDTH = NODE_WIDTH - WORD_WIDTH;
  localparam logic [3:0] OP_WRITE = 4'h1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                  state_reg;
  logic [3:0]              level_reg;
  logic                    level_ok_reg;
  logic [NODE_ADDR-1:0]    addr_reg;
  logic [9:0]              remain_reg;
  logic [WORD_WIDTH-1:0]   lo_reg;

  logic                    cfg_ready_reg;
  logic [LEVELS-1:0]       wr_en_reg;
  logic [NODE_ADDR-1:0]    wr_addr_reg;
  logic [NODE_WIDTH-1:0]   wr_data_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    err_reg;

  // Header field decode
  logic [3:0]              hdr_op;
  logic [3:0]              hdr_level;
  logic [NODE_ADDR-1:0]    hdr_base;
  logic [9:0]              hdr_count;
  logic                    hdr_illegal;
  logic                    accept;

  assign hdr_op      = cfg_word[31:28];
  assign hdr_level   = cfg_word[27:24];
  assign hdr_base    = cfg_word[12 +: NODE_ADDR];
  assign hdr_count   = cfg_word[9:0];
  assign hdr_illegal = (32'(hdr_level) >= LEVELS);
  assign accept      = cfg_valid & cfg_ready_reg;

  // One-hot decode of the latched level.
  // An illegal level decodes to all zeros, and such writes are also
  // gated by level_ok_reg.
  logic [LEVELS-1:0] level_sel;

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level_sel
      assign level_sel[gi] = (32'(level_reg) == gi);
    end
  endgenerate

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg     <= IDLE;
      level_reg     <= '0;
      level_ok_reg  <= 1'b0;
      addr_reg      <= '0;
      remain_reg    <= '0;
      lo_reg        <= '0;
      cfg_ready_reg <= 1'b1;
      wr_en_reg     <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      wr_en_reg <= '0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept && hdr_op == OP_WRITE) begin
            err_reg      <= hdr_illegal;
            level_reg    <= hdr_level;
            level_ok_reg <= ~hdr_illegal;
            addr_reg     <= hdr_base;
            remain_reg   <= hdr_count;
            if (hdr_count != 10'd0) begin
              state_reg <= LO;
              busy_reg  <= 1'b1;
            end
          end
        end
        LO: begin
          if (accept) begin
            lo_reg    <= cfg_word;
            state_reg <= HI;
          end
        end
        HI: begin
          if (accept) begin
            if (level_ok_reg) begin
              wr_en_reg   <= level_sel;
              wr_addr_reg <= addr_reg;
              wr_data_reg <= {cfg_word[HI_WIDTH-1:0], lo_reg};
            end
            // Address wraps naturally at 2^NODE_ADDR.
            addr_reg   <= addr_reg + 1'b1;
            remain_reg <= remain_reg - 1'b1;
            if (remain_reg == 10'd1) begin
              // Block input during DONE so that done lands one cycle
              // after the last write.
              state_reg     <= DONE;
              cfg_ready_reg <= 1'b0;
            end else begin
              state_reg <= LO;
            end
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b1;
          cfg_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          cfg_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_reg;
  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule
